sel_fsm_rr: RTL and testbench
=============================

Name: sel_fsm_rr

Overview:
- Parametrised N-channel successor of the single-channel request/release select FSM.
- Each channel has a request input (a) and a release input (b).
- The block grants one channel at a time with round-robin fairness, an optional maximum hold time, and a configurable idle gap between grants.
- Sits between N requesting agents and a shared resource (mux/bus); select drives the resource mux.

Parameters:
- N, 4, number of channels (>=2).
- HOLD_MAX, 0, maximum consecutive grant cycles per ownership; 0 = unlimited.
- GAP_CYCLES, 1, cycles with no grant after each release (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- a  input  N  per-channel request; a[i]=1 asks for, or keeps, the grant.
- b  input  N  per-channel release; honoured only when the owner's a is 0.
- select  output  N  one-hot grant; all-zero when nothing is granted.
- selIdx  output  $clog2(N)  index of the current or most recent owner.
- busy  output  1  high whenever state is not IDLE.
- timeout  output  1  one-cycle pulse when a grant is force-released by HOLD_MAX.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled on the clk rising edge.
- All outputs are registered (Moore style) and derived from registered state, owner, ptr and cnt.
- Reset (rst=1 at a clk edge) forces:
  - state=IDLE, owner=0, ptr=0, cnt=0;
  - select=0, selIdx=0, busy=0, timeout=0.
  - Reset wins over every other event, including mid-grant or mid-gap: select drops the next cycle.
- State IDLE:
  - Outputs: select=0, busy=0.
  - If any a is set, pick the first set bit searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Next cycle: state=GRANT, owner=idx, cnt=0, select=1<<idx, selIdx=idx.
  - Latency from a sampled high to select high is 1 cycle.
  - If no a is set, stay in IDLE.
- State GRANT (owner i). Conditions are evaluated in priority order:
  1. a[i]=1, HOLD_MAX!=0 and cnt==HOLD_MAX-1: go to GAP and pulse timeout for the first GAP cycle. select is therefore high for exactly HOLD_MAX cycles.
  2. a[i]=1: stay in GRANT, cnt+1. cnt saturates and never wraps.
  3. a[i]=0 and b[i]=1: go to GAP (normal release).
  4. a[i]=0 and b[i]=0: stay in GRANT with grant held. This is the latching behaviour; cnt does not advance.
- During GRANT, a and b of all other channels are ignored.
- State GAP:
  - Outputs: select=0, busy=1, selIdx holds the last owner.
  - On entry: cnt=0, ptr=(owner+1) mod N. The wrap is correct for N not a power of two.
  - Stay for GAP_CYCLES cycles, then go to IDLE. Arbitration happens in IDLE.
  - Minimum spacing from one grant falling to the next grant rising: GAP_CYCLES+1 cycles.
- timeout is high only in the first GAP cycle after a forced release; otherwise 0.
- cnt width is wide enough for max(HOLD_MAX, GAP_CYCLES); the counter is shared between GRANT and GAP.
- An illegal state encoding goes to IDLE next cycle with select=0.
- select is never multi-hot. select!=0 implies state==GRANT.

Decomposition:
- Shared package common holds:
  - typedef enum logic [1:0] sel_rr_state_t {SR_IDLE, SR_GRANT, SR_GAP};
  - localparam-free helper function clog2_min1 (returns at least 1 for the width of selIdx).
- One natural sub-module: rr_pick, combinational. Inputs are req[N] and ptr; outputs are found and idx.
  - Instantiated once and used in IDLE.
  - Verified standalone.

Test Plan:
- Reset then single request (N=4): rst 2 cycles, a=0001 for 1 cycle then a=0000, b=0000 → select=0001 from cycle+1, held indefinitely, selIdx=0, busy=1.
- Release (default params): owner 0, drive a=0000, b=0001 → next cycle select=0000 (GAP, busy=1), following cycle IDLE (busy=0). ptr=1 is confirmed by then driving a=0011 → select=0010.
- Round-robin wrap: a=1001 held and release each grant → grant order 0,3,0,3. From ptr=3 with a=0001 the grant goes to 0. Gaps between grants are exactly 2 zero-select cycles.
- Timeout with HOLD_MAX=3: a=0100 held continuously → select=0100 for exactly 3 cycles, then timeout=1 for 1 cycle with select=0. If a stays high, channel 2 is re-granted after the gap.
- Simultaneous/ignored inputs: owner 1, a=1110, b=1111 → grant stays on channel 1. Then a[1]=0 with b[1]=1 in the same cycle as a[3]=1 → release first. Next grant is channel 2 (ptr=2, a[2]=1), not 3.
- Reset mid-operation: assert rst during GRANT with a=1111 → next cycle all outputs 0, ptr=0. After rst drops, the first grant is channel 0. Repeat the check with GAP_CYCLES=3 and rst asserted in the middle of GAP.

Source files
------------

// File: rtl/sel_fsm_rr_pkg.sv
// Shared types and helpers for the round-robin request/release select FSM.
package sel_fsm_rr_pkg;

  // Three legal states; the fourth encoding is recovered to SR_IDLE.
  typedef enum logic [1:0] {
    SR_IDLE  = 2'd0,
    SR_GRANT = 2'd1,
    SR_GAP   = 2'd2
  } sel_rr_state_t;

  // Bits needed to hold values 0..value-1, never less than one bit so a
  // two-channel or tiny-counter instance still gets a legal vector.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/sel_fsm_rr_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N-1 back to 0.
module sel_fsm_rr_rr_pick
  import sel_fsm_rr_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] w_req2;
  logic [N-1:0]   w_rot;
  logic [IW-1:0]  w_off;
  logic [IW:0]    w_sum;

  // Rotate requests so ptr lands at bit 0, take the lowest set bit, then
  // rotate the offset back with an explicit wrap (N need not be a power of 2).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves a value unassigned and a latch can never be inferred.
    w_req2 = {req, req};
    w_rot  = N'(w_req2 >> ptr);
    w_off  = '0;
    found  = |w_rot;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = IW'(k);
    end
    w_sum = {1'b0, ptr} + {1'b0, w_off};
    if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
    idx = w_sum[IW-1:0];
  end

endmodule

// File: rtl/sel_fsm_rr.sv
// N-channel request/release select FSM with round-robin fairness, optional
// maximum hold time and a fixed idle gap after every release. All outputs
// are registered and change only with the state they describe.
module sel_fsm_rr
  import sel_fsm_rr_pkg::*;
#(
  parameter int N          = 4,
  parameter int HOLD_MAX   = 0,
  parameter int GAP_CYCLES = 1,
  localparam int IW        = clog2_min1(N),
  localparam int CNT_MAX   = (HOLD_MAX > GAP_CYCLES) ? HOLD_MAX : GAP_CYCLES,
  localparam int CW        = clog2_min1(CNT_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic [N-1:0]  select,
  output logic [IW-1:0] selIdx,
  output logic          busy,
  output logic          timeout
);

  sel_rr_state_t r_state;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_ptr;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_select;
  logic          r_busy;
  logic          r_timeout;

  logic          w_found;
  logic [IW-1:0] w_idx;
  logic [N-1:0]  w_idx_onehot;
  logic          w_own_req;
  logic          w_own_rel;
  logic          w_hold_hit;
  logic          w_gap_done;
  logic [CW-1:0] w_cnt_inc;
  logic [IW-1:0] w_ptr_next;

  sel_fsm_rr_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req   (a),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  assign w_idx_onehot = {{(N-1){1'b0}}, 1'b1} << w_idx;
  assign w_own_req    = a[r_owner];
  assign w_own_rel    = b[r_owner];
  // The HOLD_MAX==0 term keeps the unlimited case from ever matching.
  assign w_hold_hit   = (HOLD_MAX != 0) && (r_cnt == CW'(HOLD_MAX - 1));
  assign w_gap_done   = (r_cnt == CW'(GAP_CYCLES - 1));
  // Saturate rather than wrap so a long unlimited hold never aliases.
  assign w_cnt_inc    = (r_cnt == {CW{1'b1}}) ? r_cnt : r_cnt + CW'(1);
  assign w_ptr_next   = (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);

  // State, owner, pointer, counter and every output advance together.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side reads the pre-edge value regardless of statement order.
    if (rst) begin
      r_state   <= SR_IDLE;
      r_owner   <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_select  <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        SR_IDLE: begin
          if (w_found) begin
            r_state  <= SR_GRANT;
            r_owner  <= w_idx;
            r_cnt    <= '0;
            r_select <= w_idx_onehot;
            r_busy   <= 1'b1;
          end
        end

        SR_GRANT: begin
          if (w_own_req && w_hold_hit) begin
            // Forced release: owner still wants the resource but hit its limit.
            r_state   <= SR_GAP;
            r_cnt     <= '0;
            r_ptr     <= w_ptr_next;
            r_select  <= '0;
            r_timeout <= 1'b1;
          end else if (w_own_req) begin
            r_cnt <= w_cnt_inc;
          end else if (w_own_rel) begin
            r_state  <= SR_GAP;
            r_cnt    <= '0;
            r_ptr    <= w_ptr_next;
            r_select <= '0;
          end
          // a=0 and b=0: grant latches, counter frozen.
        end

        SR_GAP: begin
          if (w_gap_done) begin
            r_state <= SR_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end

        default: begin
          r_state  <= SR_IDLE;
          r_cnt    <= '0;
          r_select <= '0;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign select  = r_select;
  assign selIdx  = r_owner;
  assign busy    = r_busy;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_sel_fsm_rr.sv
// Bench for sel_fsm_rr: three instances (default, HOLD_MAX=3, GAP_CYCLES=3)
// share one stimulus stream; a per-instance reference model pushes expected
// outputs to a scoreboard queue that is popped after each clock edge.
// The picker is also checked exhaustively on its own.
module tb_sel_fsm_rr;
  import sel_fsm_rr_pkg::*;

  localparam int N    = 4;
  localparam int NDUT = 3;

  typedef struct packed {
    logic [3:0] sel;
    logic [1:0] idx;
    logic       busy;
    logic       to;
  } out_t;
  typedef out_t [NDUT-1:0] exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] sel     [NDUT];
  logic [1:0] idx     [NDUT];
  logic       busy    [NDUT];
  logic       tmo     [NDUT];

  logic [3:0] pk_req;
  logic [1:0] pk_ptr;
  logic       pk_found;
  logic [1:0] pk_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp_t sb_q[$];

  // Reference model state, one slot per instance.
  int         m_state [NDUT];
  logic [1:0] m_owner [NDUT];
  logic [1:0] m_ptr   [NDUT];
  int         m_cnt   [NDUT];
  out_t       m_out   [NDUT];

  always #5 clk = ~clk;

  sel_fsm_rr #(.N(N), .HOLD_MAX(0), .GAP_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .select(sel[0]), .selIdx(idx[0]), .busy(busy[0]), .timeout(tmo[0]));

  sel_fsm_rr #(.N(N), .HOLD_MAX(3), .GAP_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .select(sel[1]), .selIdx(idx[1]), .busy(busy[1]), .timeout(tmo[1]));

  sel_fsm_rr #(.N(N), .HOLD_MAX(0), .GAP_CYCLES(3)) u_dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .select(sel[2]), .selIdx(idx[2]), .busy(busy[2]), .timeout(tmo[2]));

  sel_fsm_rr_rr_pick #(.N(N), .IW(2)) u_pick (
    .req(pk_req), .ptr(pk_ptr), .found(pk_found), .idx(pk_idx));

  function automatic int hold_of(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  function automatic int gap_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  // Search ptr, ptr+1, ... wrapping; channel index wraps naturally in 2 bits.
  function automatic logic [1:0] ref_pick(input logic [3:0] req, input logic [1:0] p);
    logic [1:0] j;
    logic [1:0] r;
    logic       hit;
    hit = 1'b0;
    r   = 2'd0;
    for (int k = 0; k < N; k++) begin
      j = p + 2'(k);
      if (!hit && req[j]) begin
        hit = 1'b1;
        r   = j;
      end
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] av, input logic [3:0] bv,
                            input logic rv);
    int hm;
    int gc;
    hm = hold_of(k);
    gc = gap_of(k);
    m_out[k].to = 1'b0;
    if (rv) begin
      m_state[k] = 0;
      m_owner[k] = 2'd0;
      m_ptr[k]   = 2'd0;
      m_cnt[k]   = 0;
    end else begin
      case (m_state[k])
        0: if (av != 4'd0) begin
             m_owner[k] = ref_pick(av, m_ptr[k]);
             m_state[k] = 1;
             m_cnt[k]   = 0;
           end
        1: if (av[m_owner[k]] && hm != 0 && m_cnt[k] == hm - 1) begin
             m_state[k] = 2;
             m_cnt[k]   = 0;
             m_ptr[k]   = m_owner[k] + 2'd1;
             m_out[k].to = 1'b1;
           end else if (av[m_owner[k]]) begin
             if (m_cnt[k] < hm) m_cnt[k]++;
           end else if (bv[m_owner[k]]) begin
             m_state[k] = 2;
             m_cnt[k]   = 0;
             m_ptr[k]   = m_owner[k] + 2'd1;
           end
        default: if (m_cnt[k] == gc - 1) begin
             m_state[k] = 0;
             m_cnt[k]   = 0;
           end else begin
             m_cnt[k]++;
           end
      endcase
    end
    m_out[k].sel  = (m_state[k] == 1) ? (4'b0001 << m_owner[k]) : 4'b0000;
    m_out[k].idx  = m_owner[k];
    m_out[k].busy = (m_state[k] != 0);
  endtask

  // One clock: drive, predict, push; then pop and compare after the edge.
  task automatic step(input logic [3:0] av, input logic [3:0] bv, input logic rv);
    exp_t e;
    a   = av;
    b   = bv;
    rst = rv;
    for (int k = 0; k < NDUT; k++) begin
      model_step(k, av, bv, rv);
      e[k] = m_out[k];
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("d%0d.select@%0d", k, cyc), 32'(sel[k]), 32'(e[k].sel));
      check($sformatf("d%0d.selIdx@%0d", k, cyc), 32'(idx[k]), 32'(e[k].idx));
      check($sformatf("d%0d.busy@%0d", k, cyc), 32'(busy[k]), 32'(e[k].busy));
      check($sformatf("d%0d.timeout@%0d", k, cyc), 32'(tmo[k]), 32'(e[k].to));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a   = '0;
    b   = '0;
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      m_state[k] = 0;
      m_owner[k] = 2'd0;
      m_ptr[k]   = 2'd0;
      m_cnt[k]   = 0;
      m_out[k]   = '0;
    end

    // Picker on its own, every request pattern from every pointer.
    for (int r = 0; r < 16; r++) begin
      for (int p = 0; p < N; p++) begin
        pk_req = 4'(r);
        pk_ptr = 2'(p);
        #1;
        check($sformatf("pick.found r=%0h p=%0d", r, p), 32'(pk_found), 32'(r != 0));
        if (r != 0)
          check($sformatf("pick.idx r=%0h p=%0d", r, p), 32'(pk_idx), 32'(ref_pick(4'(r), 2'(p))));
      end
    end

    // Reset, then a single one-cycle request that latches.
    repeat (2) step(4'b0000, 4'b0000, 1'b1);
    step(4'b0001, 4'b0000, 1'b0);
    repeat (4) step(4'b0000, 4'b0000, 1'b0);

    // Release channel 0, then confirm ptr moved to 1.
    step(4'b0000, 4'b0001, 1'b0);
    repeat (3) step(4'b0000, 4'b0000, 1'b0);
    repeat (3) step(4'b0011, 4'b0000, 1'b0);

    // Back to idle everywhere, then round-robin between 0 and 3.
    repeat (6) step(4'b0000, 4'b1111, 1'b0);
    for (int i = 0; i < 30; i++)
      step(4'b1001 & ~m_out[0].sel, m_out[0].sel, 1'b0);

    // Continuous single request: forced release on the HOLD_MAX instance.
    repeat (6) step(4'b0000, 4'b1111, 1'b0);
    repeat (12) step(4'b0100, 4'b0000, 1'b0);

    // Owner 1 ignores other channels; release wins over a new request.
    repeat (6) step(4'b0000, 4'b1111, 1'b0);
    step(4'b0010, 4'b0000, 1'b0);
    repeat (3) step(4'b1110, 4'b1111, 1'b0);
    step(4'b1100, 4'b0010, 1'b0);
    repeat (6) step(4'b1100, 4'b0000, 1'b0);

    // Reset during a grant, then first grant after reset goes to channel 0.
    repeat (3) step(4'b1111, 4'b0000, 1'b0);
    step(4'b1111, 4'b0000, 1'b1);
    repeat (3) step(4'b1111, 4'b0000, 1'b0);

    // Reset in the middle of the long gap.
    repeat (2) step(4'b0000, 4'b1111, 1'b0);
    step(4'b0000, 4'b0000, 1'b1);
    repeat (3) step(4'b1111, 4'b0000, 1'b0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      step(4'($urandom), 4'($urandom), ($urandom_range(0, 49) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
